// File: rtl/ef_apb_master.sv
// Single-outstanding APB3 requester: valid/ready command stream in, APB SETUP/ACCESS out, valid/ready response back.
// Optional ACCESS-phase timeout abort is enabled by defining EF_APB_MASTER_TIMEOUT_EN.
module ef_apb_master #(
  parameter int unsigned AW             = 32,
  parameter int unsigned DW             = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic          PCLK,
  input  logic          PRESETn,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_write,
  input  logic [AW-1:0] cmd_addr,
  input  logic [DW-1:0] cmd_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err,
  output logic          rsp_timeout,
  output logic [AW-1:0] PADDR,
  output logic          PWRITE,
  output logic          PSEL,
  output logic          PENABLE,
  output logic [DW-1:0] PWDATA,
  input  logic [DW-1:0] PRDATA,
  input  logic          PREADY,
  input  logic          PSLVERR
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_RESP
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [AW-1:0] r_paddr, w_paddr_nxt;
  logic          r_pwrite, w_pwrite_nxt;
  logic          r_psel, w_psel_nxt;
  logic          r_penable, w_penable_nxt;
  logic [DW-1:0] r_pwdata, w_pwdata_nxt;
  logic          r_rsp_valid, w_rsp_valid_nxt;
  logic [DW-1:0] r_rsp_rdata, w_rsp_rdata_nxt;
  logic          r_rsp_err, w_rsp_err_nxt;

`ifdef EF_APB_MASTER_TIMEOUT_EN
  localparam int unsigned WCW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [WCW-1:0] WLIM = WCW'(TIMEOUT_CYCLES - 1);

  logic [WCW-1:0] r_wait, w_wait_nxt;
  logic           r_rsp_timeout, w_rsp_timeout_nxt;

  assign rsp_timeout = r_rsp_timeout;
`else
  assign rsp_timeout = 1'b0;
`endif

  assign cmd_ready = (r_state == S_IDLE) && PRESETn;
  assign PADDR     = r_paddr;
  assign PWRITE    = r_pwrite;
  assign PSEL      = r_psel;
  assign PENABLE   = r_penable;
  assign PWDATA    = r_pwdata;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

  always_comb begin
    w_state_nxt     = r_state;
    w_paddr_nxt     = r_paddr;
    w_pwrite_nxt    = r_pwrite;
    w_psel_nxt      = r_psel;
    w_penable_nxt   = r_penable;
    w_pwdata_nxt    = r_pwdata;
    w_rsp_valid_nxt = r_rsp_valid;
    w_rsp_rdata_nxt = r_rsp_rdata;
    w_rsp_err_nxt   = r_rsp_err;
`ifdef EF_APB_MASTER_TIMEOUT_EN
    w_wait_nxt        = r_wait;
    w_rsp_timeout_nxt = r_rsp_timeout;
`endif
    case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          w_paddr_nxt  = cmd_addr;
          w_pwrite_nxt = cmd_write;
          w_pwdata_nxt = cmd_write ? cmd_wdata : '0;
          w_psel_nxt   = 1'b1;
          w_state_nxt  = S_SETUP;
        end
      end
      S_SETUP: begin
        w_penable_nxt = 1'b1;
        w_state_nxt   = S_ACCESS;
      end
      S_ACCESS: begin
        if (PREADY) begin
          w_psel_nxt      = 1'b0;
          w_penable_nxt   = 1'b0;
          w_rsp_rdata_nxt = r_pwrite ? '0 : PRDATA;
          w_rsp_err_nxt   = PSLVERR;
          w_rsp_valid_nxt = 1'b1;
          w_state_nxt     = S_RESP;
`ifdef EF_APB_MASTER_TIMEOUT_EN
          w_rsp_timeout_nxt = 1'b0;
          w_wait_nxt        = '0;
`endif
        end
`ifdef EF_APB_MASTER_TIMEOUT_EN
        // this edge is the TIMEOUT_CYCLES-th wait cycle: abort instead of counting further
        else if (r_wait == WLIM) begin
          w_psel_nxt        = 1'b0;
          w_penable_nxt     = 1'b0;
          w_rsp_rdata_nxt   = '0;
          w_rsp_err_nxt     = 1'b1;
          w_rsp_timeout_nxt = 1'b1;
          w_rsp_valid_nxt   = 1'b1;
          w_wait_nxt        = '0;
          w_state_nxt       = S_RESP;
        end else begin
          w_wait_nxt = r_wait + WCW'(1);
        end
`endif
      end
      S_RESP: begin
        if (rsp_ready) begin
          w_rsp_valid_nxt = 1'b0;
          w_state_nxt     = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      r_state     <= S_IDLE;
      r_paddr     <= '0;
      r_pwrite    <= 1'b0;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_pwdata    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
`ifdef EF_APB_MASTER_TIMEOUT_EN
      r_wait        <= '0;
      r_rsp_timeout <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_paddr     <= w_paddr_nxt;
      r_pwrite    <= w_pwrite_nxt;
      r_psel      <= w_psel_nxt;
      r_penable   <= w_penable_nxt;
      r_pwdata    <= w_pwdata_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_rdata <= w_rsp_rdata_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
`ifdef EF_APB_MASTER_TIMEOUT_EN
      r_wait        <= w_wait_nxt;
      r_rsp_timeout <= w_rsp_timeout_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_ef_apb_master.sv
// Directed self-checking bench for ef_apb_master; timeout checks follow EF_APB_MASTER_TIMEOUT_EN.
module tb_ef_apb_master;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic          PCLK = 1'b0;
  logic          PRESETn;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          rsp_timeout;
  logic [AW-1:0] PADDR;
  logic          PWRITE;
  logic          PSEL;
  logic          PENABLE;
  logic [DW-1:0] PWDATA;
  logic [DW-1:0] PRDATA;
  logic          PREADY;
  logic          PSLVERR;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  ef_apb_master #(
    .AW            (AW),
    .DW            (DW),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .PCLK       (PCLK),
    .PRESETn    (PRESETn),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .rsp_timeout(rsp_timeout),
    .PADDR      (PADDR),
    .PWRITE     (PWRITE),
    .PSEL       (PSEL),
    .PENABLE    (PENABLE),
    .PWDATA     (PWDATA),
    .PRDATA     (PRDATA),
    .PREADY     (PREADY),
    .PSLVERR    (PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  // Present a command and step through its accept edge; bounded wait on cmd_ready.
  task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int unsigned n;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_wdata = d;
    n = 0;
    while (!cmd_ready && n < 20) begin
      tick();
      n++;
    end
    check("cmd_ready_wait", {63'd0, cmd_ready}, 64'd1);
    tick();
    cmd_valid = 1'b0;
  endtask

  initial begin
    int unsigned bad;
    PRESETn   = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    rsp_ready = 1'b0;
    PRDATA    = '0;
    PREADY    = 1'b1;
    PSLVERR   = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_psel", {63'd0, PSEL}, 64'd0);
    check("rst_penable", {63'd0, PENABLE}, 64'd0);
    check("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    check("rst_paddr", {32'd0, PADDR}, 64'd0);
    check("rst_pwdata", {32'd0, PWDATA}, 64'd0);
    check("rst_cmd_ready", {63'd0, cmd_ready}, 64'd0);
    PRESETn = 1'b1;
    #1;
    check("post_rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);

    // Write, zero wait states
    issue(1'b1, 32'h0000_0004, 32'h14);
    check("wr_setup_psel", {63'd0, PSEL}, 64'd1);
    check("wr_setup_penable", {63'd0, PENABLE}, 64'd0);
    check("wr_paddr", {32'd0, PADDR}, 64'h4);
    check("wr_pwdata", {32'd0, PWDATA}, 64'h14);
    check("wr_pwrite", {63'd0, PWRITE}, 64'd1);
    check("wr_cmd_ready_busy", {63'd0, cmd_ready}, 64'd0);
    tick();
    check("wr_access_penable", {63'd0, PENABLE}, 64'd1);
    check("wr_access_psel", {63'd0, PSEL}, 64'd1);
    check("wr_access_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    tick();
    check("wr_rsp_valid", {63'd0, rsp_valid}, 64'd1);
    check("wr_rsp_err", {63'd0, rsp_err}, 64'd0);
    check("wr_rsp_rdata", {32'd0, rsp_rdata}, 64'd0);
    check("wr_rsp_psel", {63'd0, PSEL}, 64'd0);
    check("wr_rsp_penable", {63'd0, PENABLE}, 64'd0);
    rsp_ready = 1'b1;
    tick();
    check("wr_done_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    check("wr_done_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    check("idle_paddr_kept", {32'd0, PADDR}, 64'h4);
    check("idle_pwdata_kept", {32'd0, PWDATA}, 64'h14);
    rsp_ready = 1'b0;

    // Read with 3 wait states; PSLVERR noise during waits must be ignored
    PREADY  = 1'b0;
    PRDATA  = 32'hDEAD_BEEF;
    PSLVERR = 1'b1;
    issue(1'b0, 32'h0000_0010, 32'h55);
    check("rd_pwdata_zero", {32'd0, PWDATA}, 64'd0);
    check("rd_pwrite", {63'd0, PWRITE}, 64'd0);
    check("rd_paddr", {32'd0, PADDR}, 64'h10);
    tick();
    check("rd_access_penable", {63'd0, PENABLE}, 64'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rd_wait_psel", {63'd0, PSEL}, 64'd1);
      check("rd_wait_penable", {63'd0, PENABLE}, 64'd1);
      check("rd_wait_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    end
    PREADY  = 1'b1;
    PSLVERR = 1'b0;
    tick();
    check("rd_rsp_valid", {63'd0, rsp_valid}, 64'd1);
    check("rd_rsp_rdata", {32'd0, rsp_rdata}, 64'hDEAD_BEEF);
    check("rd_rsp_err", {63'd0, rsp_err}, 64'd0);
    check("rd_rsp_timeout", {63'd0, rsp_timeout}, 64'd0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // Read completing with slave error
    PRDATA  = 32'h1234_5678;
    PSLVERR = 1'b1;
    issue(1'b0, 32'h0000_0020, 32'h0);
    tick();
    tick();
    check("err_rsp_valid", {63'd0, rsp_valid}, 64'd1);
    check("err_rsp_err", {63'd0, rsp_err}, 64'd1);
    check("err_rsp_timeout", {63'd0, rsp_timeout}, 64'd0);
    check("err_rsp_rdata", {32'd0, rsp_rdata}, 64'h1234_5678);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    PSLVERR = 1'b0;
    check("err_idle_paddr_kept", {32'd0, PADDR}, 64'h20);

    // Back-to-back commands with stalled response
    issue(1'b1, 32'h0000_0008, 32'hA5);
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 32'h0000_000C;
    cmd_wdata = 32'h0;
    PRDATA    = 32'h0BAD_F00D;
    tick();
    tick();
    check("b2b_first_rsp_valid", {63'd0, rsp_valid}, 64'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("b2b_hold_rsp_valid", {63'd0, rsp_valid}, 64'd1);
      check("b2b_hold_rsp_rdata", {32'd0, rsp_rdata}, 64'd0);
      check("b2b_hold_rsp_err", {63'd0, rsp_err}, 64'd0);
      check("b2b_hold_cmd_ready", {63'd0, cmd_ready}, 64'd0);
      check("b2b_hold_psel", {63'd0, PSEL}, 64'd0);
    end
    rsp_ready = 1'b1;
    tick();
    check("b2b_hs_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    check("b2b_hs_psel", {63'd0, PSEL}, 64'd0);
    check("b2b_hs_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    tick();
    cmd_valid = 1'b0;
    check("b2b_second_psel", {63'd0, PSEL}, 64'd1);
    check("b2b_second_paddr", {32'd0, PADDR}, 64'hC);
    check("b2b_second_pwrite", {63'd0, PWRITE}, 64'd0);
    tick();
    tick();
    check("b2b_second_rsp_valid", {63'd0, rsp_valid}, 64'd1);
    check("b2b_second_rsp_rdata", {32'd0, rsp_rdata}, 64'h0BAD_F00D);
    tick();
    rsp_ready = 1'b0;

    // Slave never ready
    PREADY = 1'b0;
    issue(1'b0, 32'h0000_0030, 32'h0);
    tick();
`ifdef EF_APB_MASTER_TIMEOUT_EN
    for (int i = 0; i < 15; i++) tick();
    check("to_still_waiting_psel", {63'd0, PSEL}, 64'd1);
    check("to_still_waiting_valid", {63'd0, rsp_valid}, 64'd0);
    tick();
    check("to_rsp_valid", {63'd0, rsp_valid}, 64'd1);
    check("to_rsp_err", {63'd0, rsp_err}, 64'd1);
    check("to_rsp_timeout", {63'd0, rsp_timeout}, 64'd1);
    check("to_rsp_rdata", {32'd0, rsp_rdata}, 64'd0);
    check("to_psel", {63'd0, PSEL}, 64'd0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    issue(1'b0, 32'h0000_0030, 32'h0);
    tick();
    tick();
`else
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (!PSEL || !PENABLE || rsp_valid) bad++;
    end
    check("no_timeout_stall", bad, 0);
    check("no_timeout_flag", {63'd0, rsp_timeout}, 64'd0);
`endif

    // Reset pulse during a stalled ACCESS
    PRESETn = 1'b0;
    #1;
    check("mid_rst_cmd_ready", {63'd0, cmd_ready}, 64'd0);
    tick();
    PRESETn = 1'b1;
    PREADY  = 1'b1;
    check("mid_rst_psel", {63'd0, PSEL}, 64'd0);
    check("mid_rst_penable", {63'd0, PENABLE}, 64'd0);
    check("mid_rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    check("mid_rst_paddr", {32'd0, PADDR}, 64'd0);
    #1;
    check("mid_rst_cmd_ready_after", {63'd0, cmd_ready}, 64'd1);
    tick();
    check("mid_rst_no_late_rsp", {63'd0, rsp_valid}, 64'd0);
    issue(1'b1, 32'h0000_0004, 32'h99);
    check("post_rst_wr_pwdata", {32'd0, PWDATA}, 64'h99);
    tick();
    tick();
    check("post_rst_wr_rsp_valid", {63'd0, rsp_valid}, 64'd1);
    check("post_rst_wr_rsp_err", {63'd0, rsp_err}, 64'd0);
    check("post_rst_wr_rsp_rdata", {32'd0, rsp_rdata}, 64'd0);
    rsp_ready = 1'b1;
    tick();
    check("post_rst_wr_done", {63'd0, rsp_valid}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
